// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: tile-job sequencer for a ROWS x COLS weight-stationary systolic array
//   clk, reset_n         clock, asynchronous active-low reset
//   i_start, i_num_vec   job request (sampled in IDLE) and activation vector count
//   o_busy, o_done       job in progress, one-cycle end-of-job pulse
//   o_wet_rd_*           weight SRAM read request (bottom row first)
//   o_act_rd_*           activation SRAM read request
//   o_pe_*               PE broadcast controls: weight clear, top-row select, MAC enable
//   o_act_valid          per-row skewed activation valid
//   o_out_valid          per-column result valid at the array bottom
module systolic_array_ctrl #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int VEC_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_start,
    input  logic [VEC_W-1:0]        i_num_vec,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_wet_rd_en,
    output logic [$clog2(ROWS)-1:0] o_wet_rd_addr,
    output logic                    o_act_rd_en,
    output logic [VEC_W-1:0]        o_act_rd_addr,
    output logic                    o_pe_clear_weight,
    output logic                    o_pe_weight_sel,
    output logic                    o_pe_mac_enable,
    output logic [ROWS-1:0]         o_act_valid,
    output logic [COLS-1:0]         o_out_valid
);
    localparam int CW = $clog2(ROWS + COLS + 1);
    localparam int SL = ROWS + COLS;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LOAD_W = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_STREAM = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic [2:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [VEC_W-1:0] r_vec_len;
    logic [VEC_W-1:0] r_vec_cnt;
    logic             r_wsel;
    logic [SL-1:0]    r_skew;
    logic             w_wet_en;
    logic             w_act_en;

    assign w_wet_en = r_state == S_LOAD_W;
    assign w_act_en = r_state == S_STREAM;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_vec_len <= '0;
            r_vec_cnt <= '0;
            r_wsel    <= 1'b0;
            r_skew    <= '0;
        end else begin
            // Select follows the read by one cycle so it lines up with returned weight data.
            r_wsel <= w_wet_en;
            // Bit 0 is the activation data-return cycle; bit j is that cycle delayed j more.
            r_skew <= {r_skew[SL-2:0], w_act_en};
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state   <= S_CLEAR;
                        r_vec_len <= i_num_vec;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_LOAD_W;
                    r_cnt   <= CW'(ROWS - 1);
                end
                S_LOAD_W: begin
                    if (r_cnt == '0) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= CW'(ROWS - 1);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state   <= (r_vec_len != '0) ? S_STREAM : S_DONE;
                        r_vec_cnt <= r_vec_len;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_STREAM: begin
                    // Down-count to 1 so a full-scale vec_len never wraps the counter.
                    if (r_vec_cnt == VEC_W'(1)) begin
                        r_state <= S_DRAIN;
                        r_cnt   <= CW'(ROWS + COLS - 1);
                    end else begin
                        r_vec_cnt <= r_vec_cnt - VEC_W'(1);
                    end
                end
                S_DRAIN: begin
                    // The final drain cycle is the one carrying the last out_valid bit.
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy            = r_state != S_IDLE;
    assign o_done            = r_state == S_DONE;
    assign o_pe_clear_weight = r_state == S_CLEAR;
    assign o_wet_rd_en       = w_wet_en;
    // Counter runs ROWS-1 down to 0, so the bottom row is fetched first.
    assign o_wet_rd_addr     = w_wet_en ? r_cnt[$clog2(ROWS)-1:0] : '0;
    assign o_act_rd_en       = w_act_en;
    assign o_act_rd_addr     = w_act_en ? r_vec_len - r_vec_cnt : '0;
    assign o_pe_weight_sel   = r_wsel;
    assign o_act_valid       = r_skew[ROWS-1:0];
    assign o_out_valid       = r_skew[SL-1:ROWS];
    // Activations stream contiguously, so any live skew bit means MAC work is in flight.
    assign o_pe_mac_enable   = |r_skew;
endmodule
